bcd_display_scanner: RTL

- Upstream neighbour of the BCD-to-7-segment decoder on a multiplexed common-anode display.
- Holds an N-digit BCD word and time-multiplexes one digit per refresh slot onto a single 4-bit BCD bus that feeds one decoder instance.
- Drives active-low digit anodes.
- Accepts new display values through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg_pkg.sv | 6 +
 rtl/bcd_display_scanner_if.sv | 10 +
 rtl/scan_prescaler.sv | 17 +
 rtl/bcd_display_scanner.sv | 90 +++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: BCD types and constants shared by the scanned 7-segment display blocks.
package seg_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
    typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: valid/ready channel carrying a full N-digit BCD word into the scanner.
interface bcd_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] din;
    logic                    din_valid;
    logic                    din_ready;
    modport master (output din, output din_valid, input din_ready);
    modport slave (input din, input din_valid, output din_ready);
endinterface

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running 0..REFRESH_DIV-1 counter; tick marks the last cycle of each slot.
module scan_prescaler #(
    parameter int REFRESH_DIV = 50000,
    localparam int DIV_W = $clog2(REFRESH_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == DIV_W'(REFRESH_DIV - 1);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: multiplexes an N-digit BCD word onto one decoder bus with active-low anodes.
// New words are committed only at frame wrap; define BCD_SCAN_LZB_EN for leading-zero blanking.
module bcd_display_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_display_scanner_if.slave  bus,
    output bcd_t                  bcd_out,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_start
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic                          tick, wrap, xfer, commit;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] disp_q, disp_d, pend_q, pend_d, lzb;
    logic                          pflag_q, pflag_d, ready_q, ready_d, started_q;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    bcd_t                          bcd_q, bcd_d;
    logic                          fs_q, fs_d;

    scan_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

`ifdef BCD_SCAN_LZB_EN
    logic seen;
    // Digits above the most significant non-zero digit blank; digit 0 always shows.
    always_comb begin
        seen = 1'b0;
        lzb  = pend_q;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen = seen | (pend_q[i] != 4'd0);
            if (!seen) lzb[i] = BCD_BLANK;
        end
    end
`else
    assign lzb = pend_q;
`endif

    always_comb begin
        wrap    = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        idx_d   = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
        xfer    = bus.din_valid && ready_q;
        commit  = wrap && pflag_q;
        pend_d  = xfer ? bus.din : pend_q;
        pflag_d = xfer || (pflag_q && !commit);
        ready_d = !pflag_d;
        disp_d  = commit ? lzb : disp_q;
        an_d    = ~(ONE << idx_d);
        bcd_d   = disp_d[idx_d];
        fs_d    = !started_q || wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            disp_q    <= '1;
            pend_q    <= '1;
            pflag_q   <= 1'b0;
            ready_q   <= 1'b1;
            started_q <= 1'b0;
            an_q      <= '1;
            bcd_q     <= BCD_BLANK;
            fs_q      <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pflag_q   <= pflag_d;
            ready_q   <= ready_d;
            started_q <= 1'b1;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
            fs_q      <= fs_d;
        end
    end

    assign bus.din_ready = ready_q;
    assign an_n          = an_q;
    assign bcd_out       = bcd_q;
    assign frame_start   = fs_q;
endmodule
